// File: rtl/net_tx_segmenter_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : network_types (package)
//  Description : Shared types for the TX segmentation path: header magic,
//                packed segment header layout and segmenter state encoding.
//  Revision    : 1.0 - initial release
// ============================================================================
package network_types;

    // Fixed marker in every segment header so the receiver can sanity-check framing
    localparam logic [7:0] NET_HDR_MAGIC = 8'hA5;

    // Header occupies the low 48 bits of the header beat; msg_id sits in bits [15:0]
    typedef struct packed {
        logic [7:0]  magic;
        logic [7:0]  dest;
        logic [15:0] seg_idx;
        logic [15:0] msg_id;
    } net_seg_hdr_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HDR  = 2'd1,
        ST_BODY = 2'd2
    } seg_state_t;

endpackage
`default_nettype wire

// File: rtl/net_tx_segmenter_out_slot.sv
`default_nettype none
// ============================================================================
//  Module      : axis_out_slot
//  Description : One-entry registered AXI-Stream output stage. All outputs
//                come from flops; "free" tells the producer it may load.
//  Revision    : 1.0 - initial release
// ============================================================================
module axis_out_slot #(
    parameter int DATA_BITS = 512
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   load_i,
    input  logic [DATA_BITS-1:0]   data_i,
    input  logic [DATA_BITS/8-1:0] keep_i,
    input  logic                   last_i,
    input  logic                   ready_i,
    output logic                   valid_o,
    output logic [DATA_BITS-1:0]   data_o,
    output logic [DATA_BITS/8-1:0] keep_o,
    output logic                   last_o,
    output logic                   free_o
);

    logic                   valid_q;
    logic [DATA_BITS-1:0]   data_q;
    logic [DATA_BITS/8-1:0] keep_q;
    logic                   last_q;

    // Slot can accept a new beat when empty or when its current beat leaves this cycle
    assign free_o  = !valid_q || ready_i;
    assign valid_o = valid_q;
    assign data_o  = data_q;
    assign keep_o  = keep_q;
    assign last_o  = last_q;

    // Load only happens while free, so payload stays frozen during a stall
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            keep_q  <= '0;
            last_q  <= 1'b0;
        end else if (load_i) begin
            valid_q <= 1'b1;
            data_q  <= data_i;
            keep_q  <= keep_i;
            last_q  <= last_i;
        end else if (ready_i) begin
            valid_q <= 1'b0;
        end
    end

endmodule
`default_nettype wire

// File: rtl/net_tx_segmenter.sv
`default_nettype none
// ============================================================================
//  Module      : net_tx_segmenter
//  Description : Splits AXI-Stream messages into packets of at most
//                MAX_SEG_BEATS payload beats, each preceded by a header beat
//                carrying message id, segment index and destination node.
//  Revision    : 1.0 - initial release
// ============================================================================
module net_tx_segmenter
    import network_types::*;
#(
    parameter int MAX_SEG_BEATS = 22,
    parameter int DATA_BITS     = 512
) (
    input  logic                   aclk,
    input  logic                   aresetn,
    input  logic [DATA_BITS-1:0]   s_axis_tdata,
    input  logic [DATA_BITS/8-1:0] s_axis_tkeep,
    input  logic                   s_axis_tvalid,
    input  logic                   s_axis_tlast,
    output logic                   s_axis_tready,
    output logic [DATA_BITS-1:0]   m_axis_tdata,
    output logic [DATA_BITS/8-1:0] m_axis_tkeep,
    output logic                   m_axis_tvalid,
    output logic                   m_axis_tlast,
    input  logic                   m_axis_tready,
    input  logic [7:0]             dest_node,
    output logic [31:0]            pkt_count,
    output logic [31:0]            msg_count
);

    localparam int          KEEP_BITS   = DATA_BITS / 8;
    localparam logic [15:0] C_LAST_BEAT = 16'(MAX_SEG_BEATS - 1);

    logic [1:0]             rst_sync_q;
    logic                   rst_n;
    seg_state_t             state_q, state_d;
    logic [15:0]            msg_id_q, msg_id_d;
    logic [15:0]            seg_idx_q, seg_idx_d;
    logic [15:0]            beat_cnt_q, beat_cnt_d;
    logic [31:0]            msg_count_q, msg_count_d;
    logic [31:0]            pkt_count_q;
    net_seg_hdr_t           hdr;
    logic                   in_hs;
    logic                   slot_free;
    logic                   slot_load;
    logic [DATA_BITS-1:0]   slot_data;
    logic [KEEP_BITS-1:0]   slot_keep;
    logic                   slot_last;

    // Reset asserts immediately but releases two clocks later, aligned to aclk
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) rst_sync_q <= 2'b00;
        else          rst_sync_q <= {rst_sync_q[0], 1'b1};
    end
    assign rst_n = rst_sync_q[1];

    assign hdr           = '{magic: NET_HDR_MAGIC, dest: dest_node, seg_idx: seg_idx_q, msg_id: msg_id_q};
    assign s_axis_tready = (state_q == ST_BODY) && slot_free;
    assign in_hs         = s_axis_tvalid && s_axis_tready;
    assign pkt_count     = pkt_count_q;
    assign msg_count     = msg_count_q;

    // Next-state logic: header load in IDLE/HDR, payload pass-through and segment accounting in BODY
    always_comb begin
        state_d     = state_q;
        msg_id_d    = msg_id_q;
        seg_idx_d   = seg_idx_q;
        beat_cnt_d  = beat_cnt_q;
        msg_count_d = msg_count_q;
        slot_load   = 1'b0;
        slot_data   = '0;
        slot_keep   = '0;
        slot_last   = 1'b0;
        case (state_q)
            ST_IDLE, ST_HDR: begin
                // A new message waits for valid; a continuation header goes out regardless
                if (slot_free && (s_axis_tvalid || (state_q == ST_HDR))) begin
                    slot_load = 1'b1;
                    slot_data = DATA_BITS'(hdr);
                    slot_keep = '1;
                    state_d   = ST_BODY;
                end
            end
            ST_BODY: begin
                if (in_hs) begin
                    slot_load = 1'b1;
                    slot_data = s_axis_tdata;
                    slot_keep = s_axis_tkeep;
                    slot_last = s_axis_tlast || (beat_cnt_q == C_LAST_BEAT);
                    if (slot_last) begin
                        beat_cnt_d = '0;
                        // Message end wins when it coincides with a full segment
                        if (s_axis_tlast) begin
                            msg_id_d    = msg_id_q + 16'd1;
                            seg_idx_d   = '0;
                            msg_count_d = msg_count_q + 32'd1;
                            state_d     = ST_IDLE;
                        end else begin
                            seg_idx_d   = seg_idx_q + 16'd1;
                            state_d     = ST_HDR;
                        end
                    end else begin
                        beat_cnt_d = beat_cnt_q + 16'd1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and per-message bookkeeping registers
    always_ff @(posedge aclk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            msg_id_q    <= '0;
            seg_idx_q   <= '0;
            beat_cnt_q  <= '0;
            msg_count_q <= '0;
        end else begin
            state_q     <= state_d;
            msg_id_q    <= msg_id_d;
            seg_idx_q   <= seg_idx_d;
            beat_cnt_q  <= beat_cnt_d;
            msg_count_q <= msg_count_d;
        end
    end

    // Count packets as they actually leave on the output
    always_ff @(posedge aclk or negedge rst_n) begin
        if (!rst_n)                                            pkt_count_q <= '0;
        else if (m_axis_tvalid && m_axis_tready && m_axis_tlast) pkt_count_q <= pkt_count_q + 32'd1;
    end

    axis_out_slot #(
        .DATA_BITS (DATA_BITS)
    ) u_out_slot (
        .clk_i   (aclk),
        .rst_ni  (rst_n),
        .load_i  (slot_load),
        .data_i  (slot_data),
        .keep_i  (slot_keep),
        .last_i  (slot_last),
        .ready_i (m_axis_tready),
        .valid_o (m_axis_tvalid),
        .data_o  (m_axis_tdata),
        .keep_o  (m_axis_tkeep),
        .last_o  (m_axis_tlast),
        .free_o  (slot_free)
    );

endmodule
`default_nettype wire

// File: tb/tb_net_tx_segmenter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_net_tx_segmenter
//  Description : Directed self-checking bench for net_tx_segmenter, using a
//                22-beat instance and a 1-beat-segment instance.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_net_tx_segmenter;

    typedef struct packed {
        logic [63:0] d;
        logic [7:0]  k;
        logic        l;
    } beat_t;

    logic        aclk;
    logic        aresetn;
    logic [7:0]  dest_node;
    // instance A: MAX_SEG_BEATS = 22
    logic [63:0] s_tdata, m_tdata;
    logic [7:0]  s_tkeep, m_tkeep;
    logic        s_tvalid, s_tlast, s_tready, m_tvalid, m_tlast, m_tready;
    logic [31:0] pkt_count, msg_count;
    // instance B: MAX_SEG_BEATS = 1
    logic [63:0] b_s_tdata, b_m_tdata;
    logic [7:0]  b_s_tkeep, b_m_tkeep;
    logic        b_s_tvalid, b_s_tlast, b_s_tready, b_m_tvalid, b_m_tlast, b_m_tready;
    logic [31:0] b_pkt_count, b_msg_count;

    int    n_checks = 0;
    int    n_fail   = 0;
    int    lens[$];
    beat_t obs[$];
    beat_t exp_q[$];

    net_tx_segmenter #(.MAX_SEG_BEATS(22), .DATA_BITS(64)) dut (
        .aclk(aclk), .aresetn(aresetn),
        .s_axis_tdata(s_tdata), .s_axis_tkeep(s_tkeep), .s_axis_tvalid(s_tvalid),
        .s_axis_tlast(s_tlast), .s_axis_tready(s_tready),
        .m_axis_tdata(m_tdata), .m_axis_tkeep(m_tkeep), .m_axis_tvalid(m_tvalid),
        .m_axis_tlast(m_tlast), .m_axis_tready(m_tready),
        .dest_node(dest_node), .pkt_count(pkt_count), .msg_count(msg_count)
    );

    net_tx_segmenter #(.MAX_SEG_BEATS(1), .DATA_BITS(64)) dut1 (
        .aclk(aclk), .aresetn(aresetn),
        .s_axis_tdata(b_s_tdata), .s_axis_tkeep(b_s_tkeep), .s_axis_tvalid(b_s_tvalid),
        .s_axis_tlast(b_s_tlast), .s_axis_tready(b_s_tready),
        .m_axis_tdata(b_m_tdata), .m_axis_tkeep(b_m_tkeep), .m_axis_tvalid(b_m_tvalid),
        .m_axis_tlast(b_m_tlast), .m_axis_tready(b_m_tready),
        .dest_node(dest_node), .pkt_count(b_pkt_count), .msg_count(b_msg_count)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    function automatic logic [63:0] pay(input int m, input int b);
        return {8'hDA, m[23:0], b[31:0]};
    endfunction

    function automatic logic [7:0] kp(input int b);
        return ((b % 5) == 4) ? 8'h00 : 8'hFF;
    endfunction

    // Reference stream: header before every MAX-beat chunk, last on chunk or message end
    function automatic void build_expected(input int max, input logic [7:0] dest, input logic [15:0] msg0);
        logic [15:0] msg, seg;
        exp_q.delete();
        msg = msg0;
        foreach (lens[m]) begin
            seg = 16'd0;
            for (int b = 0; b < lens[m]; b++) begin
                if ((b % max) == 0) begin
                    exp_q.push_back('{d: {16'h0000, 8'hA5, dest, seg, msg}, k: 8'hFF, l: 1'b0});
                    seg = seg + 16'd1;
                end
                exp_q.push_back('{d: pay(m, b), k: kp(b),
                                  l: (b == lens[m] - 1) || ((b % max) == max - 1)});
            end
            msg = msg + 16'd1;
        end
    endfunction

    task automatic drive_idle();
        s_tvalid = 1'b0; s_tlast = 1'b0; s_tdata = '0; s_tkeep = '0; m_tready = 1'b1;
        b_s_tvalid = 1'b0; b_s_tlast = 1'b0; b_s_tdata = '0; b_s_tkeep = '0; b_m_tready = 1'b1;
    endtask

    task automatic apply_reset();
        aresetn = 1'b0;
        drive_idle();
        repeat (2) @(posedge aclk);
        #1 aresetn = 1'b1;
        repeat (3) @(posedge aclk);
        #1;
    endtask

    // Sends every message in lens to instance A (sel=0) or B (sel=1); records output handshakes
    task automatic run_traffic(input bit sel, input int rdy_pct, input int vld_pct, input int max_cyc);
        int    mi = 0, bi = 0, cyc = 0;
        bit    cur_v = 1'b0, hold = 1'b0, done_prev, rdy, lst;
        beat_t held, cur_o;
        logic  ov, srdy;
        obs.delete();
        held = '0;
        forever begin
            @(posedge aclk); #1;
            rdy = ($urandom_range(99) < rdy_pct);
            lst = 1'b0;
            if (mi < lens.size()) begin
                if (!cur_v) cur_v = ($urandom_range(99) < vld_pct);
                lst = (bi == lens[mi] - 1);
            end else begin
                cur_v = 1'b0;
            end
            if (!sel) begin
                m_tready = rdy; s_tvalid = cur_v; s_tdata = pay(mi, bi); s_tkeep = kp(bi); s_tlast = lst;
            end else begin
                b_m_tready = rdy; b_s_tvalid = cur_v; b_s_tdata = pay(mi, bi); b_s_tkeep = kp(bi); b_s_tlast = lst;
            end
            @(negedge aclk);
            ov    = sel ? b_m_tvalid : m_tvalid;
            cur_o = sel ? {b_m_tdata, b_m_tkeep, b_m_tlast} : {m_tdata, m_tkeep, m_tlast};
            srdy  = sel ? b_s_tready : s_tready;
            if (hold) begin
                n_checks++;
                if (!ov || cur_o !== held) begin
                    n_fail++;
                    $display("FAIL stall_stable: got v=%b d=%h k=%h l=%b, need v=1 d=%h k=%h l=%b",
                             ov, cur_o.d, cur_o.k, cur_o.l, held.d, held.k, held.l);
                end
            end
            hold = ov && !rdy;
            held = cur_o;
            if (ov && rdy) obs.push_back(cur_o);
            done_prev = (mi >= lens.size());
            if (cur_v && srdy) begin
                cur_v = 1'b0;
                bi++;
                if (bi == lens[mi]) begin mi++; bi = 0; end
            end
            if (done_prev && !ov) break;
            cyc++;
            if (cyc > max_cyc) begin
                n_checks++; n_fail++;
                $display("FAIL traffic_timeout: got %0d of %0d messages sent, need all within %0d cycles",
                         mi, lens.size(), max_cyc);
                break;
            end
        end
        drive_idle();
    endtask

    task automatic test_reset();
        apply_reset();
        n_checks++; if (m_tvalid !== 1'b0) begin n_fail++; $display("FAIL rst_valid: got %b need 0", m_tvalid); end
        n_checks++; if (m_tdata !== 64'h0) begin n_fail++; $display("FAIL rst_data: got %h need 0", m_tdata); end
        n_checks++; if (m_tkeep !== 8'h0) begin n_fail++; $display("FAIL rst_keep: got %h need 0", m_tkeep); end
        n_checks++; if (m_tlast !== 1'b0) begin n_fail++; $display("FAIL rst_last: got %b need 0", m_tlast); end
        n_checks++; if (s_tready !== 1'b0) begin n_fail++; $display("FAIL rst_sready: got %b need 0", s_tready); end
        n_checks++; if (pkt_count !== 32'd0) begin n_fail++; $display("FAIL rst_pkt: got %0d need 0", pkt_count); end
        n_checks++; if (msg_count !== 32'd0) begin n_fail++; $display("FAIL rst_msg: got %0d need 0", msg_count); end
        n_checks++; if (b_m_tvalid !== 1'b0) begin n_fail++; $display("FAIL rst_b_valid: got %b need 0", b_m_tvalid); end
    endtask

    task automatic test_single_msg();
        apply_reset();
        lens = '{3};
        run_traffic(1'b0, 100, 100, 200);
        n_checks++; if (obs.size() !== 4) begin n_fail++; $display("FAIL single_len: got %0d need 4", obs.size()); end
        if (obs.size() == 4) begin
            n_checks++; if (obs[0].d !== 64'h0000_A503_0000_0000) begin n_fail++; $display("FAIL single_hdr: got %h need 0000a50300000000", obs[0].d); end
            n_checks++; if (obs[0].k !== 8'hFF || obs[0].l !== 1'b0) begin n_fail++; $display("FAIL single_hdr_kl: got k=%h l=%b need k=ff l=0", obs[0].k, obs[0].l); end
            n_checks++; if (obs[3].l !== 1'b1 || obs[2].l !== 1'b0) begin n_fail++; $display("FAIL single_last: got %b%b need 01", obs[2].l, obs[3].l); end
            n_checks++; if (obs[2].d !== 64'hDA00_0000_0000_0001) begin n_fail++; $display("FAIL single_pay: got %h need da00000000000001", obs[2].d); end
        end
        n_checks++; if (pkt_count !== 32'd1) begin n_fail++; $display("FAIL single_pkt: got %0d need 1", pkt_count); end
        n_checks++; if (msg_count !== 32'd1) begin n_fail++; $display("FAIL single_msg: got %0d need 1", msg_count); end
    endtask

    task automatic test_segmentation();
        apply_reset();
        lens = '{50, 5};
        run_traffic(1'b0, 100, 100, 500);
        n_checks++; if (obs.size() !== 59) begin n_fail++; $display("FAIL seg_len: got %0d need 59", obs.size()); end
        if (obs.size() == 59) begin
            n_checks++; if (obs[23].d !== 64'h0000_A503_0001_0000) begin n_fail++; $display("FAIL seg_hdr1: got %h need 0000a50300010000", obs[23].d); end
            n_checks++; if (obs[46].d !== 64'h0000_A503_0002_0000) begin n_fail++; $display("FAIL seg_hdr2: got %h need 0000a50300020000", obs[46].d); end
            n_checks++; if (obs[53].d !== 64'h0000_A503_0000_0001) begin n_fail++; $display("FAIL seg_msg2_hdr: got %h need 0000a50300000001", obs[53].d); end
            n_checks++; if (obs[22].l !== 1'b1 || obs[21].l !== 1'b0) begin n_fail++; $display("FAIL seg_cut: got %b%b need 01", obs[21].l, obs[22].l); end
        end
        build_expected(22, 8'h03, 16'h0000);
        foreach (exp_q[i]) if (i < obs.size()) begin
            n_checks++;
            if (obs[i] !== exp_q[i]) begin n_fail++; $display("FAIL seg_beat[%0d]: got %h need %h", i, obs[i], exp_q[i]); end
        end
        n_checks++; if (pkt_count !== 32'd4) begin n_fail++; $display("FAIL seg_pkt: got %0d need 4", pkt_count); end
    endtask

    task automatic test_exact_multiple();
        apply_reset();
        lens = '{44};
        run_traffic(1'b0, 100, 100, 300);
        n_checks++; if (obs.size() !== 46) begin n_fail++; $display("FAIL exact_len: got %0d need 46", obs.size()); end
        if (obs.size() == 46) begin
            n_checks++; if (obs[45].l !== 1'b1) begin n_fail++; $display("FAIL exact_last: got %b need 1", obs[45].l); end
            n_checks++; if (obs[23].d !== 64'h0000_A503_0001_0000) begin n_fail++; $display("FAIL exact_hdr1: got %h need 0000a50300010000", obs[23].d); end
        end
        n_checks++; if (pkt_count !== 32'd2) begin n_fail++; $display("FAIL exact_pkt: got %0d need 2", pkt_count); end
        repeat (3) @(posedge aclk);
        @(negedge aclk);
        n_checks++; if (m_tvalid !== 1'b0 || s_tready !== 1'b0) begin n_fail++; $display("FAIL exact_idle: got v=%b r=%b need 0 0", m_tvalid, s_tready); end
    endtask

    task automatic test_max_seg_one();
        apply_reset();
        lens = '{3};
        run_traffic(1'b1, 100, 100, 200);
        n_checks++; if (obs.size() !== 6) begin n_fail++; $display("FAIL max1_len: got %0d need 6", obs.size()); end
        if (obs.size() == 6) begin
            n_checks++; if (obs[2].d !== 64'h0000_A503_0001_0000) begin n_fail++; $display("FAIL max1_hdr1: got %h need 0000a50300010000", obs[2].d); end
            n_checks++; if (obs[4].d !== 64'h0000_A503_0002_0000) begin n_fail++; $display("FAIL max1_hdr2: got %h need 0000a50300020000", obs[4].d); end
            n_checks++; if ({obs[1].l, obs[3].l, obs[5].l} !== 3'b111) begin n_fail++; $display("FAIL max1_last: got %b%b%b need 111", obs[1].l, obs[3].l, obs[5].l); end
        end
        n_checks++; if (b_pkt_count !== 32'd3) begin n_fail++; $display("FAIL max1_pkt: got %0d need 3", b_pkt_count); end
    endtask

    task automatic test_backpressure();
        int npkt = 0;
        apply_reset();
        lens.delete();
        for (int i = 0; i < 1000; i++) begin
            lens.push_back(int'($urandom_range(30, 1)));
            npkt += (lens[i] + 21) / 22;
        end
        run_traffic(1'b0, 50, 70, 70000);
        build_expected(22, 8'h03, 16'h0000);
        n_checks++; if (obs.size() !== exp_q.size()) begin n_fail++; $display("FAIL bp_len: got %0d need %0d", obs.size(), exp_q.size()); end
        foreach (exp_q[i]) if (i < obs.size()) begin
            n_checks++;
            if (obs[i] !== exp_q[i]) begin n_fail++; $display("FAIL bp_beat[%0d]: got %h need %h", i, obs[i], exp_q[i]); end
        end
        n_checks++; if (pkt_count !== 32'(npkt)) begin n_fail++; $display("FAIL bp_pkt: got %0d need %0d", pkt_count, npkt); end
        n_checks++; if (msg_count !== 32'd1000) begin n_fail++; $display("FAIL bp_msg: got %0d need 1000", msg_count); end
    endtask

    task automatic test_msgid_wrap();
        apply_reset();
        @(negedge aclk);
        force dut.msg_id_q = 16'hFFFF;
        @(negedge aclk);
        release dut.msg_id_q;
        lens = '{2, 2};
        run_traffic(1'b0, 100, 100, 200);
        n_checks++; if (obs.size() !== 6) begin n_fail++; $display("FAIL wrap_len: got %0d need 6", obs.size()); end
        if (obs.size() == 6) begin
            n_checks++; if (obs[0].d !== 64'h0000_A503_0000_FFFF) begin n_fail++; $display("FAIL wrap_hdr0: got %h need 0000a5030000ffff", obs[0].d); end
            n_checks++; if (obs[3].d !== 64'h0000_A503_0000_0000) begin n_fail++; $display("FAIL wrap_hdr1: got %h need 0000a50300000000", obs[3].d); end
        end
    endtask

    task automatic test_reset_midpacket();
        apply_reset();
        s_tvalid = 1'b1; s_tlast = 1'b0; s_tdata = 64'h1234_5678_9ABC_DEF0; s_tkeep = 8'hFF; m_tready = 1'b1;
        repeat (30) @(posedge aclk);
        @(negedge aclk);
        n_checks++; if (pkt_count !== 32'd1) begin n_fail++; $display("FAIL mid_pkt_before: got %0d need 1", pkt_count); end
        n_checks++; if (m_tvalid !== 1'b1) begin n_fail++; $display("FAIL mid_valid_before: got %b need 1", m_tvalid); end
        aresetn = 1'b0;
        #1;
        n_checks++; if (m_tvalid !== 1'b0 || m_tlast !== 1'b0) begin n_fail++; $display("FAIL mid_rst_valid: got v=%b l=%b need 0 0", m_tvalid, m_tlast); end
        n_checks++; if (pkt_count !== 32'd0 || msg_count !== 32'd0) begin n_fail++; $display("FAIL mid_rst_cnt: got %0d/%0d need 0/0", pkt_count, msg_count); end
        drive_idle();
        repeat (2) @(posedge aclk);
        #1 aresetn = 1'b1;
        repeat (3) @(posedge aclk);
        #1;
        lens = '{1};
        run_traffic(1'b0, 100, 100, 100);
        n_checks++; if (obs.size() !== 2) begin n_fail++; $display("FAIL mid_after_len: got %0d need 2", obs.size()); end
        if (obs.size() == 2) begin
            n_checks++; if (obs[0].d !== 64'h0000_A503_0000_0000) begin n_fail++; $display("FAIL mid_after_hdr: got %h need 0000a50300000000", obs[0].d); end
        end
    endtask

    initial begin
        aresetn   = 1'b0;
        dest_node = 8'h03;
        drive_idle();
        test_reset();
        test_single_msg();
        test_segmentation();
        test_exact_multiple();
        test_max_seg_one();
        test_msgid_wrap();
        test_reset_midpacket();
        test_backpressure();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/net_tx_segmenter.md
# net_tx_segmenter

Splits application TX messages (AXI4-Stream, `tlast` per message) into network packets of at most `MAX_SEG_BEATS` payload beats. Prepends one header beat per packet carrying message id, segment index and destination node. Sits in the PCIe/application clock domain directly upstream of the TX clock-domain-crossing stage that feeds the network-clock side. Its output is a packet stream whose `tlast` marks packet boundaries, not message boundaries.

## Interface
Parameters:
- `MAX_SEG_BEATS`, 22: maximum payload beats per packet, excluding the header; legal range 1..65535.
- `DATA_BITS`, 512: stream data width; keep width is `DATA_BITS/8`.

Ports:
- `aclk`  in  1  application/PCIe clock; all logic is single-clock.
- `aresetn`  in  1  asynchronous, active-low reset.
- `s_axis`  axi_stream.slave  data `DATA_BITS`, keep `DATA_BITS/8`, valid/ready/last  application message stream.
- `m_axis`  axi_stream.master  same widths  packetised stream toward the TX crossing.
- `dest_node`  in  8  destination node id; sampled only when a header is built.
- `pkt_count`  out  32  number of packets completed on `m_axis` (`tlast` handshakes); wraps.
- `msg_count`  out  32  number of input messages fully consumed; wraps.

## Operation
- State machine with three states:
  - IDLE: waiting for a new message.
  - HDR: emit the header beat.
  - BODY: forward payload beats.
- IDLE: when `s_axis.valid`=1 and the output register is free, load the header and go to BODY. The input beat is not consumed in this cycle.
- HDR: entered after a segment boundary inside a message. The header is loaded when the output register is free, independent of `s_axis.valid`; then go to BODY.
- Header beat layout:
  - data[15:0] = `msg_id`
  - data[31:16] = `seg_idx`
  - data[39:32] = `dest_node`
  - data[47:40] = 8'hA5 (magic)
  - all other data bits 0
  - keep all ones; last = 0.
- BODY: each input handshake is copied to the output register with data and keep unmodified.
  - Output last = `s_axis.last` OR (`beat_cnt` == `MAX_SEG_BEATS-1`).
  - `beat_cnt` increments per body beat and clears at each output last.
- End of segment, by case:
  - Input last set: `msg_id`++, `seg_idx`←0, `msg_count`++, go to IDLE.
  - Input last clear: `seg_idx`++, go to HDR.
  - Both coincide (message length is an exact multiple of `MAX_SEG_BEATS`): treat as message end. No empty trailing packet is produced.
- Width and wrap rules: `msg_id` and `seg_idx` are 16 bits and wrap modulo 2^16. `beat_cnt` is 16 bits. Counters are plain modulo 2^32.
- Beats with keep=0 are forwarded unchanged; they count toward `beat_cnt`.
- `dest_node` changes mid-message take effect at the next header only.

## Timing
- Output is a single registered slot: `m_axis.valid`, data, keep and last all come from flops.
- Slot is "free" when `!m_axis.valid || m_axis.ready`.
- `s_axis.ready` = (state==BODY) && free; it is combinational from `m_axis.ready`.
- Latency:
  - First header appears on `m_axis` 1 cycle after `s_axis.valid` rises in IDLE.
  - Each payload beat appears 1 cycle after its input handshake.
- Throughput with `m_axis.ready` held high: one header bubble per packet. A message of N beats occupies N + ceil(N/`MAX_SEG_BEATS`) output cycles.
- Handshake rules:
  - `m_axis` data, keep and last are stable while valid && !ready.
  - valid never drops without a handshake.
- Reset values (async assertion, synchronous-to-`aclk` release through a 2-flop deassert synchroniser):
  - `m_axis.valid`=0, data=0, keep=0, last=0.
  - `s_axis.ready`=0; state=IDLE.
  - `msg_id`, `seg_idx`, `beat_cnt`, `pkt_count`, `msg_count` = 0.
- Reset mid-packet: the in-flight packet is truncated without `tlast`. The downstream crossing is reset in the same domain and discards it.

## Structure
- Shared package `network_types`: add `NET_HDR_MAGIC`=8'hA5, a packed `net_seg_hdr_t` struct {magic, dest, seg_idx, msg_id}, and a state enum `seg_state_t`.
- Optional sub-module `axis_out_slot`: the one-entry registered output holding data/keep/last/valid and generating "free".
- Everything else stays in `net_tx_segmenter`.

## Test plan
- Single 3-beat message, `MAX_SEG_BEATS`=22, `dest_node`=8'h03, ready high -> 4 output beats; header = 0x..A5_03_0000_0000; last on beat 4; `pkt_count`=1, `msg_count`=1.
- 50-beat message, `MAX_SEG_BEATS`=22 -> packets of 22/22/6 payload beats; headers `seg_idx` 0,1,2 with `msg_id` 0; `pkt_count`=3; second message uses `msg_id`=1, `seg_idx`=0.
- 44-beat message (exact multiple) -> exactly 2 packets, no empty third packet; state returns to IDLE.
- `MAX_SEG_BEATS`=1, 3-beat message -> 6 output beats, alternating header/payload, each payload beat has last=1.
- Random `m_axis.ready` (50%) and `s_axis.valid` (70%) backpressure over 1000 messages -> payload byte-for-byte identical to a scoreboard; output signals stable under stall; no beat lost or duplicated.
- Force `msg_id` to 16'hFFFF then send 2 messages -> headers show FFFF then 0000. Assert `aresetn` mid-packet -> `m_axis.valid` low immediately, all counters 0, next message starts with `msg_id` 0.
